// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch: two-entry (main + skid) pipeline latch with flush and saturating stall counter.
module pipe_skid_latch #(
    parameter int PC_WIDTH = 32,
    parameter int IR_WIDTH = 32,
    parameter logic [IR_WIDTH-1:0] NOP_IR = '0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic [IR_WIDTH-1:0]  in_ir,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [IR_WIDTH-1:0]  out_ir,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state_q, state_d;
    logic [PC_WIDTH-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [IR_WIDTH-1:0] main_ir_q, main_ir_d, skid_ir_q, skid_ir_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic accept, consume;
    assign in_ready  = state_q != TWO;
    assign out_valid = state_q != EMPTY;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_pc    = out_valid ? main_pc_q : '0;
    assign out_ir    = out_valid ? main_ir_q : NOP_IR;
    assign stall_cnt = cnt_q;
    assign cnt_d     = (out_valid && !out_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_comb begin
        state_d   = state_q;
        main_pc_d = main_pc_q;
        main_ir_d = main_ir_q;
        skid_pc_d = skid_pc_q;
        skid_ir_d = skid_ir_q;
        if (flush) begin
            state_d   = EMPTY;
            main_pc_d = '0;
            main_ir_d = NOP_IR;
            skid_pc_d = '0;
            skid_ir_d = NOP_IR;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d   = ONE;
                    main_pc_d = in_pc;
                    main_ir_d = in_ir;
                end
                ONE: if (accept && !consume) begin
                    state_d   = TWO;
                    skid_pc_d = in_pc;
                    skid_ir_d = in_ir;
                end else if (accept) begin
                    main_pc_d = in_pc;
                    main_ir_d = in_ir;
                end else if (consume) begin
                    state_d = EMPTY;
                end
                TWO: if (consume) begin
                    state_d   = ONE;
                    main_pc_d = skid_pc_q;
                    main_ir_d = skid_ir_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            main_pc_q <= '0;
            main_ir_q <= NOP_IR;
            skid_pc_q <= '0;
            skid_ir_q <= NOP_IR;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            main_pc_q <= main_pc_d;
            main_ir_q <= main_ir_d;
            skid_pc_q <= skid_pc_d;
            skid_ir_q <= skid_ir_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_skid_latch.sv
// tb_pipe_skid_latch: directed vector table, stall saturation sequence and randomized queue-model check.
module tb_pipe_skid_latch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clock = 0, reset_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, flush = 0;
    logic [31:0] in_pc = 0, in_ir = 0, out_pc, out_ir;
    logic [3:0] stall_cnt;
    int passed = 0, total = 0;

    pipe_skid_latch #(.PC_WIDTH(32), .IR_WIDTH(32), .NOP_IR(NOP), .CNT_WIDTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .flush(flush), .stall_cnt(stall_cnt));

    always #5 clock = ~clock;

    typedef struct {
        logic r, iv; logic [31:0] pc; logic ordy, fl;
        logic ird, ov; logic [31:0] opc; logic [3:0] cnt;
    } vec_t;
    typedef struct { logic [31:0] pc, ir; } ent_t;
    vec_t vec[19];
    ent_t q[$];
    int mcnt;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    endtask

    task automatic step(input logic r, input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        reset_n = r; in_valid = iv; in_pc = pc; in_ir = ~pc; out_ready = ordy; flush = fl;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_model(input int idx);
        chk("rnd_in_ready", idx, {31'b0, in_ready}, {31'b0, q.size() < 2});
        chk("rnd_out_valid", idx, {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("rnd_out_pc", idx, out_pc, q.size() > 0 ? q[0].pc : 32'h0);
        chk("rnd_out_ir", idx, out_ir, q.size() > 0 ? q[0].ir : NOP);
        chk("rnd_stall_cnt", idx, {28'b0, stall_cnt}, mcnt);
    endtask

    initial begin
        vec[0]  = '{0,0,32'h00,0,0, 1,0,32'h00,0};
        vec[1]  = '{1,1,32'h00,1,0, 1,1,32'h00,0};
        vec[2]  = '{1,1,32'h04,1,0, 1,1,32'h04,0};
        vec[3]  = '{1,1,32'h08,1,0, 1,1,32'h08,0};
        vec[4]  = '{1,0,32'h00,1,0, 1,0,32'h00,0};
        vec[5]  = '{1,1,32'h10,0,0, 1,1,32'h10,0};
        vec[6]  = '{1,1,32'h14,0,0, 0,1,32'h10,1};
        vec[7]  = '{1,0,32'h00,1,0, 1,1,32'h14,1};
        vec[8]  = '{1,0,32'h00,1,0, 1,0,32'h00,1};
        vec[9]  = '{1,1,32'h30,0,0, 1,1,32'h30,1};
        vec[10] = '{1,1,32'h34,0,0, 0,1,32'h30,2};
        vec[11] = '{1,1,32'h20,0,1, 1,0,32'h00,3};
        vec[12] = '{1,0,32'h00,1,0, 1,0,32'h00,3};
        vec[13] = '{1,1,32'h40,0,0, 1,1,32'h40,3};
        vec[14] = '{1,1,32'h44,0,0, 0,1,32'h40,4};
        vec[15] = '{1,0,32'h00,0,0, 0,1,32'h40,5};
        vec[16] = '{0,1,32'h48,1,0, 1,0,32'h00,0};
        vec[17] = '{1,1,32'h4C,1,0, 1,1,32'h4C,0};
        vec[18] = '{1,0,32'h00,1,0, 1,0,32'h00,0};
        @(negedge clock);
        for (int i = 0; i < 19; i++) begin
            step(vec[i].r, vec[i].iv, vec[i].pc, vec[i].ordy, vec[i].fl);
            chk("in_ready", i, {31'b0, in_ready}, {31'b0, vec[i].ird});
            chk("out_valid", i, {31'b0, out_valid}, {31'b0, vec[i].ov});
            chk("out_pc", i, out_pc, vec[i].opc);
            chk("out_ir", i, out_ir, vec[i].ov ? ~vec[i].opc : NOP);
            chk("stall_cnt", i, {28'b0, stall_cnt}, {28'b0, vec[i].cnt});
        end
        // Stall counter saturation with held data stable throughout
        step(0, 0, 0, 0, 0);
        step(1, 1, 32'h100, 0, 0);
        chk("sat_start", 0, {28'b0, stall_cnt}, 0);
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 0, 0, 0);
            chk("sat_cnt", i, {28'b0, stall_cnt}, i > 15 ? 15 : i);
            chk("sat_hold", i, out_pc, 32'h100);
        end
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0);
        chk("sat_after_flush", 0, {28'b0, stall_cnt}, 15);
        chk("sat_flushed", 0, {31'b0, out_valid}, 0);
        // Randomized run against a queue model
        step(0, 0, 0, 0, 0);
        q.delete();
        mcnt = 0;
        chk_model(-1);
        for (int c = 0; c < 10000; c++) begin
            logic r, iv, ordy, fl, acc, con;
            logic [31:0] pc, ir;
            r = ($urandom_range(0, 499) != 0);
            iv = $urandom_range(0, 1);
            ordy = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            pc = $urandom;
            ir = $urandom;
            reset_n = r; in_valid = iv; in_pc = pc; in_ir = ir; out_ready = ordy; flush = fl;
            acc = iv && q.size() < 2;
            con = ordy && q.size() > 0;
            if (!r) begin
                q.delete();
                mcnt = 0;
            end else begin
                if (q.size() > 0 && !ordy && mcnt < 15) mcnt++;
                if (fl) q.delete();
                else begin
                    if (con) void'(q.pop_front());
                    if (acc) q.push_back('{pc, ir});
                end
            end
            @(posedge clock);
            @(negedge clock);
            chk_model(c);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of the program-counter field.
REQ-002 Parameter IR_WIDTH, default 32, width of the instruction field.
REQ-003 Parameter NOP_IR, default all-zeros of IR_WIDTH, instruction presented on out_ir when out_valid is 0.
REQ-004 Parameter CNT_WIDTH, default 16, width of the stall-cycle counter.
REQ-005 The block SHALL have one clock, and reset SHALL be synchronous and active-low.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 in_valid  input  1  upstream offers in_pc/in_ir this cycle.
REQ-009 in_ready  output  1  block accepts an offer this cycle; registered, no combinational path from any input.
REQ-010 in_pc  input  PC_WIDTH  upstream PC.
REQ-011 in_ir  input  IR_WIDTH  upstream instruction.
REQ-012 out_valid  output  1  out_pc/out_ir hold a live entry.
REQ-013 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-014 out_pc  output  PC_WIDTH  head-entry PC; 0 when out_valid is 0.
REQ-015 out_ir  output  IR_WIDTH  head-entry instruction; NOP_IR when out_valid is 0.
REQ-016 flush  input  1  discard all held entries (branch mispredict / exception).
REQ-017 stall_cnt  output  CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Storage SHALL be two entries: main (drives outputs) and skid; state SHALL be one of EMPTY, ONE (main only), TWO (main and skid).
REQ-019 Accept SHALL occur when in_valid and in_ready; consume SHALL occur when out_valid and out_ready.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO.
REQ-021 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-022 Latency SHALL be one cycle: an entry accepted at edge N appears on out_pc/out_ir after edge N when the block was EMPTY or when ONE with a simultaneous consume.
REQ-023 Transitions absent flush: EMPTY+accept->ONE; ONE+accept, no consume->TWO (input to skid); ONE+consume, no accept->EMPTY; ONE+accept+consume->ONE (input to main); TWO+consume->ONE (skid moves to main); otherwise hold.
REQ-024 Entries SHALL leave in exactly acceptance order; no entry dropped or duplicated absent flush.
REQ-025 flush SHALL take priority over accept and consume: next state EMPTY, any same-cycle accept discarded, stored data cleared.
REQ-026 While flush is 1, in_ready SHALL still follow REQ-020 from current state; upstream treats the cycle's transfer as lost.
REQ-027 stall_cnt SHALL increment by 1 per cycle with out_valid=1 and out_ready=0, saturate at all-ones, and be unaffected by flush.
REQ-028 Held data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 On a clock edge with reset_n=0: state EMPTY, in_ready=1, out_valid=0, out_pc=0, out_ir=NOP_IR, stall_cnt=0.
REQ-030 reset_n SHALL override flush, accept and consume; entries held mid-operation are discarded.
REQ-031 After reset release the first accept SHALL be possible on the first edge with reset_n=1.

Verification
REQ-032 Streaming: out_ready=1, in_valid=1 with pc 0x0,0x4,0x8 on three edges -> out_pc 0x0,0x4,0x8 one cycle later each, in_ready stays 1.
REQ-033 Backpressure: out_ready=0, push pc 0x10 then 0x14 -> state TWO, in_ready=0, out_pc=0x10; raise out_ready -> out_pc 0x14 next cycle, then out_valid=0.
REQ-034 Flush: state TWO, flush=1 with in_valid=1 pc 0x20 -> next cycle out_valid=0, out_ir=NOP_IR, in_ready=1, 0x20 never appears.
REQ-035 Stall counter: CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-036 Reset mid-operation: state TWO, stall_cnt=5, drive reset_n=0 one edge -> out_valid=0, in_ready=1, stall_cnt=0, out_pc=0.
REQ-037 Random: random in_valid/out_ready/flush for 10000 cycles vs scoreboard -> order preserved, no loss except flushed entries, in_ready never 1 in TWO.
